// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - opcode constants and sequencer state encoding shared by the arithmetic blocks
package arith_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_INC = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_MUL  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

endpackage

// File: rtl/fullAdder4b.sv
// rtl/fullAdder4b.sv - 4-bit ripple-carry adder, the sole arithmetic element of the sequencer
module fullAdder4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[4];

endmodule

// File: rtl/adder_op_sequencer.sv
// rtl/adder_op_sequencer.sv - one-at-a-time ADD/SUB/INC/MUL sequencer driving a shared fullAdder4b
module adder_op_sequencer
  import arith_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MUL_ITERS = WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-1:0] res_data,
  output logic               res_cout,
  output logic               busy
);

  localparam int CNT_W = $clog2(MUL_ITERS);

  state_t             state, state_nxt;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   m_q;      // operand A; multiplicand during MUL
  logic [WIDTH-1:0]   q_q;      // operand B; multiplier shift register during MUL
  logic [WIDTH-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] res_data_q;
  logic               res_cout_q;

  logic [WIDTH-1:0]   add_a, add_b, add_sum;
  logic               add_cin, add_cout;
  logic [WIDTH-1:0]   acc_nxt, q_nxt;

  fullAdder4b u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    add_a   = m_q;
    add_b   = '0;
    add_cin = 1'b0;
    case (state)
      ST_EXEC: begin
        case (op_q)
          OP_ADD: add_b = q_q;
          OP_SUB: begin
            add_b   = ~q_q;
            add_cin = 1'b1;
          end
          OP_INC: add_cin = 1'b1;
          default: ;
        endcase
      end
      ST_MUL: begin
        add_a = acc_q;
        add_b = q_q[0] ? m_q : '0;
      end
      default: ;
    endcase
  end

  // {C,A,Q} >> 1 with C taken straight from the adder carry
  assign acc_nxt = {add_cout, add_sum[WIDTH-1:1]};
  assign q_nxt   = {add_sum[0], q_q[WIDTH-1:1]};

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req_valid) state_nxt = (req_op == OP_MUL) ? ST_MUL : ST_EXEC;
      ST_EXEC: state_nxt = ST_DONE;
      ST_MUL:  if (&cnt_q) state_nxt = ST_DONE;
      ST_DONE: if (res_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      op_q       <= '0;
      m_q        <= '0;
      q_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      res_data_q <= '0;
      res_cout_q <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: if (req_valid) begin
          op_q  <= req_op;
          m_q   <= req_a;
          q_q   <= req_b;
          acc_q <= '0;
          cnt_q <= '0;
        end
        ST_EXEC: begin
          res_data_q <= {{WIDTH{1'b0}}, add_sum};
          res_cout_q <= add_cout;
        end
        ST_MUL: begin
          acc_q <= acc_nxt;
          q_q   <= q_nxt;
          cnt_q <= cnt_q + CNT_W'(1);
          if (&cnt_q) begin
            res_data_q <= {acc_nxt, q_nxt};
            res_cout_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready = (state == ST_IDLE);
  assign res_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign res_data  = res_data_q;
  assign res_cout  = res_cout_q;

endmodule

// File: tb/tb_adder_op_sequencer.sv
// tb/tb_adder_op_sequencer.sv - randomized self-checking bench for adder_op_sequencer
module tb_adder_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = 2'b00;
  logic [3:0] req_a = 4'h0;
  logic [3:0] req_b = 4'h0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_data;
  logic       res_cout;
  logic       busy;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  adder_op_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_cout  (res_cout),
    .busy      (busy)
  );

  // {cout, data} from plain integer arithmetic
  function automatic logic [8:0] model(input logic [1:0] op, input int a, input int b);
    int r;
    case (op)
      2'b00:   r = a + b;
      2'b01:   r = a - b + 16;
      2'b10:   r = a + 1;
      default: return {1'b0, 8'(a * b)};
    endcase
    return {1'((r >> 4) & 1), 8'(r & 15)};
  endfunction

  // Issues one request, waits for the result, optionally stalls, then completes the handshake.
  task automatic do_op(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b, input int stall,
                       output logic [7:0] data, output logic cout, output int lat,
                       output logic stable, output logic busy_ok);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 2'($urandom); req_a = 4'($urandom); req_b = 4'($urandom);
    lat = 0; busy_ok = 1'b1;
    while (!res_valid && lat < 20) begin
      if (!busy || req_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    data = res_data; cout = res_cout; stable = 1'b1;
    repeat (stall) begin
      @(posedge clk); #1;
      if (!res_valid || res_data !== data || res_cout !== cout || req_ready) stable = 1'b0;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    if (res_valid || !req_ready || busy) stable = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b1; req_op = 2'b00; req_a = 4'h5; req_b = 4'h6;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if ({req_ready, res_valid, res_data, res_cout, busy} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      mismatched++;
      $display("FAIL reset_state: got ready=%b valid=%b data=%h cout=%b busy=%b want 1 0 00 0 0",
               req_ready, res_valid, res_data, res_cout, busy);
    end
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    compared++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_no_accept: got busy=%b ready=%b want 0 1", busy, req_ready);
    end
  endtask

  task automatic check_directed(input string name, input logic [1:0] op, input logic [3:0] a,
                                input logic [3:0] b, input logic [7:0] exp_data, input logic exp_cout);
    logic [7:0] d; logic c; int lat; logic st, bo; int exp_lat;
    exp_lat = (op == 2'b11) ? 4 : 1;
    do_op(op, a, b, int'($urandom_range(0, 2)), d, c, lat, st, bo);
    compared++;
    if (d !== exp_data || c !== exp_cout || lat != exp_lat || !st || !bo) begin
      mismatched++;
      $display("FAIL %s: got data=%h cout=%b lat=%0d stable=%b busy_ok=%b want data=%h cout=%b lat=%0d 1 1",
               name, d, c, lat, st, bo, exp_data, exp_cout, exp_lat);
    end
  endtask

  task automatic test_add_inc();
    check_directed("add_9_8",   2'b00, 4'd9,  4'd8, 8'h01, 1'b1);
    check_directed("add_15_15", 2'b00, 4'd15, 4'd15, 8'h0E, 1'b1);
    check_directed("inc_15",    2'b10, 4'd15, 4'd7, 8'h00, 1'b1);
    check_directed("inc_6",     2'b10, 4'd6,  4'd9, 8'h07, 1'b0);
  endtask

  task automatic test_sub();
    check_directed("sub_5_3", 2'b01, 4'd5, 4'd3, 8'h02, 1'b1);
    check_directed("sub_3_5", 2'b01, 4'd3, 4'd5, 8'h0E, 1'b0);
    check_directed("sub_7_7", 2'b01, 4'd7, 4'd7, 8'h00, 1'b1);
  endtask

  task automatic test_mul();
    check_directed("mul_15_15", 2'b11, 4'd15, 4'd15, 8'hE1, 1'b0);
    check_directed("mul_0_9",   2'b11, 4'd0,  4'd9,  8'h00, 1'b0);
    check_directed("mul_13_11", 2'b11, 4'd13, 4'd11, 8'h8F, 1'b0);
  endtask

  task automatic test_backpressure();
    int waited;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b00; req_a = 4'd2; req_b = 4'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    waited = 0;
    while (!res_valid && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req_valid = 1'($urandom); req_op = 2'($urandom); req_a = 4'($urandom); req_b = 4'($urandom);
      @(posedge clk); #1;
      compared++;
      if (res_valid !== 1'b1 || res_data !== 8'h05 || res_cout !== 1'b0 || req_ready !== 1'b0 || busy !== 1'b1) begin
        mismatched++;
        $display("FAIL bp_hold[%0d]: got valid=%b data=%h cout=%b ready=%b busy=%b want 1 05 0 0 1",
                 i, res_valid, res_data, res_cout, req_ready, busy);
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    compared++;
    if (res_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL bp_release: got valid=%b ready=%b busy=%b want 0 1 0", res_valid, req_ready, busy);
    end
    check_directed("add_after_bp", 2'b00, 4'd4, 4'd4, 8'h08, 1'b0);
  endtask

  task automatic test_reset_mid_mul();
    logic saw_valid;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b11; req_a = 4'd15; req_b = 4'd15;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    compared++;
    if ({req_ready, res_valid, res_data, res_cout, busy} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      mismatched++;
      $display("FAIL reset_mid_mul: got ready=%b valid=%b data=%h cout=%b busy=%b want 1 0 00 0 0",
               req_ready, res_valid, res_data, res_cout, busy);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (res_valid || busy) saw_valid = 1'b1;
    end
    compared++;
    if (saw_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_mid_mul_quiet: got activity=%b want 0", saw_valid);
    end
    check_directed("add_1_1_after_reset", 2'b00, 4'd1, 4'd1, 8'h02, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] d; logic c; int lat; logic st, bo;
    logic [1:0] op; logic [3:0] a, b; logic [8:0] exp;
    for (int i = 0; i < 200; i++) begin
      op = 2'($urandom); a = 4'($urandom); b = 4'($urandom);
      exp = model(op, int'(a), int'(b));
      do_op(op, a, b, int'($urandom_range(0, 4)), d, c, lat, st, bo);
      compared++;
      if ({c, d} !== exp || lat != ((op == 2'b11) ? 4 : 1) || !st || !bo) begin
        mismatched++;
        $display("FAIL random op=%0d a=%0d b=%0d: got cout=%b data=%h lat=%0d stable=%b busy_ok=%b want cout=%b data=%h",
                 op, a, b, c, d, lat, st, bo, exp[8], exp[7:0]);
      end
    end
  endtask

  task automatic test_sweep();
    logic [7:0] d; logic c; int lat; logic st, bo; logic [8:0] exp;
    for (int op = 0; op < 4; op++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          exp = model(2'(op), a, b);
          do_op(2'(op), 4'(a), 4'(b), int'($urandom_range(0, 1)), d, c, lat, st, bo);
          compared++;
          if ({c, d} !== exp || lat != ((op == 3) ? 4 : 1) || !st || !bo) begin
            mismatched++;
            $display("FAIL sweep op=%0d a=%0d b=%0d: got cout=%b data=%h lat=%0d stable=%b busy_ok=%b want cout=%b data=%h",
                     op, a, b, c, d, lat, st, bo, exp[8], exp[7:0]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_inc();
    test_sub();
    test_mul();
    test_backpressure();
    test_reset_mid_mul();
    test_random();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
